// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle command path.
// Requester indices, arbiter FSM encoding and the default auto-repeat period.
// Pure declarations: no logic, no latency, no backpressure.
package pong_pkg;

  // Requester indices into the 4-bit pulse/pending vectors
  localparam int REQ_P1_UP = 0;
  localparam int REQ_P1_DN = 1;
  localparam int REQ_P2_UP = 2;
  localparam int REQ_P2_DN = 3;

  // Default auto-repeat period in clk cycles and the counter width that holds it
  localparam int REPEAT_CYC_DEFAULT = 5_000_000;
  localparam int RPT_W_DEFAULT      = 23;

  // Arbiter FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/paddle_cmd_arbiter_if.sv
// Paddle-move command channel between the arbiter and the paddle updater.
// Latency: wires only.
// Backpressure: valid/ready; the master holds cmd_valid/cmd_id until cmd_ready.
interface paddle_cmd_arbiter_if;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/rr_pick4.sv
// Round-robin priority picker over four requests, searching upward from ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any
);

  // First set request at ptr, ptr+1, ... with 2-bit wraparound
  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt_idx = 2'd0;
    any     = |req;
    found   = 1'b0;
    idx     = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_cmd_arbiter.sv
// Latches player button pulses into sticky pending flags and round-robins them onto a command channel.
// Latency: pulse -> pending next edge -> cmd_valid the edge after; at most one command per 2 cycles.
// Backpressure: an offer is held stable until cmd_ready; new presses keep accumulating (or drop) meanwhile.
// Optional auto-repeat on held buttons is built when PADDLE_AUTO_REPEAT_EN is defined.
import pong_pkg::*;

module paddle_cmd_arbiter #(
  parameter int N_REQ      = 4,
  parameter int REPEAT_CYC = REPEAT_CYC_DEFAULT,
  parameter int RPT_W      = RPT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     pulse,
  input  logic [N_REQ-1:0]     held,
  paddle_cmd_arbiter_if.master cmd,
  output logic [N_REQ-1:0]     pending,
  output logic                 dropped
);

  arb_state_t       state;
  logic             valid_q;
  logic [1:0]       id_q;
  logic [1:0]       rr_ptr;
  logic [1:0]       win_idx;
  logic             win_any;
  logic             grant;
  logic [N_REQ-1:0] rpt_fire;
  logic [N_REQ-1:0] set_evt;
  logic [N_REQ-1:0] grant_mask;
  logic [N_REQ-1:0] offer_mask;
  logic [N_REQ-1:0] merged;
  logic [N_REQ-1:0] pending_nxt;
  logic             drop_evt;

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_id    = id_q;

  rr_pick4 u_pick (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  // A grant only happens from IDLE while the game runs
  assign grant = (state == ST_IDLE) && enable && win_any;

`ifdef PADDLE_AUTO_REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt [N_REQ];
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

  for (genvar g = 0; g < N_REQ; g++) begin : g_rpt
    // Per-button repeat timer: runs while held and enabled, restarts on release
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_cnt[g] <= '0;
      end else if (!held[g]) begin
        rpt_cnt[g] <= '0;
      end else if (enable) begin
        rpt_cnt[g] <= (rpt_cnt[g] == RPT_LAST) ? '0 : rpt_cnt[g] + 1'b1;
      end
    end
    assign rpt_fire[g] = held[g] && enable && (rpt_cnt[g] == RPT_LAST);
  end
`else
  // Pulse-only build: held and the repeat settings have no effect
  localparam bit unused_cfg = (REPEAT_CYC > 0) && (RPT_W > 0);
  logic unused_held;
  assign unused_held = ^held;
  assign rpt_fire    = '0;
`endif

  // Next pending vector: grant clears, new events set, opposite directions cancel
  always_comb begin
    grant_mask = '0;
    offer_mask = '0;
    if (grant)   grant_mask[win_idx] = 1'b1;
    if (valid_q) offer_mask[id_q]    = 1'b1;
    set_evt  = enable ? (pulse | rpt_fire) : '0;
    drop_evt = |(set_evt & pending & ~grant_mask);
    merged   = (pending & ~grant_mask) | set_evt;
    pending_nxt = merged;
    if (merged[REQ_P1_UP] && merged[REQ_P1_DN] &&
        !offer_mask[REQ_P1_UP] && !offer_mask[REQ_P1_DN]) begin
      pending_nxt[REQ_P1_UP] = 1'b0;
      pending_nxt[REQ_P1_DN] = 1'b0;
    end
    if (merged[REQ_P2_UP] && merged[REQ_P2_DN] &&
        !offer_mask[REQ_P2_UP] && !offer_mask[REQ_P2_DN]) begin
      pending_nxt[REQ_P2_UP] = 1'b0;
      pending_nxt[REQ_P2_DN] = 1'b0;
    end
    if (!enable) pending_nxt = '0;
  end

  // Pending flags and the sticky drop indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (drop_evt) dropped <= 1'b1;
    end
  end

  // Offer FSM: load the winner in IDLE, hold it in OFFER until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= 2'd0;
      rr_ptr  <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            valid_q <= 1'b1;
            id_q    <= win_idx;
            state   <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (cmd.cmd_ready) begin
            valid_q <= 1'b0;
            rr_ptr  <= id_q + 2'd1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_cmd_arbiter.sv
// Bench for paddle_cmd_arbiter: scoreboard of expected command IDs plus direct timing/flag checks.
// Auto-repeat scenario is included when PADDLE_AUTO_REPEAT_EN is defined.
module tb_paddle_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] pulse;
  logic [3:0] held;
  logic [3:0] pending;
  logic       dropped;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  paddle_cmd_arbiter_if cmd_if ();

  paddle_cmd_arbiter #(
    .N_REQ      (4),
    .REPEAT_CYC (8),
    .RPT_W      (23)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .pulse   (pulse),
    .held    (held),
    .cmd     (cmd_if),
    .pending (pending),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until no offer and nothing pending
  task automatic wait_idle();
    int n;
    n = 0;
    while ((cmd_if.cmd_valid || pending != 4'd0) && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, (n < 40)}, 32'd1);
  endtask

  // Scoreboard: every accepted command must match the next expected ID
  always @(negedge clk) begin
    if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", {30'd0, cmd_if.cmd_id}, 32'hFFFF);
      else chk("cmd_id", {30'd0, cmd_if.cmd_id}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; pulse = 4'd0; held = 4'd0; cmd_if.cmd_ready = 1'b1;
    #3;
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
    chk("rst_id", {30'd0, cmd_if.cmd_id}, 32'd0);
    chk("rst_dropped", {31'd0, dropped}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Single press: pending after one edge, valid for exactly one cycle after two
    pulse = 4'b0001; exp_q.push_back(0);
    step(); pulse = 4'd0;
    chk("single_pending", {28'd0, pending}, 32'h1);
    chk("single_valid_early", {31'd0, cmd_if.cmd_valid}, 32'd0);
    step();
    chk("single_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
    chk("single_id", {30'd0, cmd_if.cmd_id}, 32'd0);
    chk("single_pending_clr", {28'd0, pending}, 32'd0);
    step();
    chk("single_valid_drop", {31'd0, cmd_if.cmd_valid}, 32'd0);
    wait_idle();

    // All four at once: both pairs annul, no command, no drop
    pulse = 4'b1111;
    step(); pulse = 4'd0;
    chk("annul_pending", {28'd0, pending}, 32'd0);
    step(); step();
    chk("annul_no_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
    chk("annul_no_drop", {31'd0, dropped}, 32'd0);

    // Pointer is 1 (last accept was ID 0): 0101 -> 2 then 0
    pulse = 4'b0101; exp_q.push_back(2); exp_q.push_back(0);
    step(); pulse = 4'd0;
    wait_idle();

    // Pointer back at 0 via reset: 0101 -> 0 then 2
    rst = 1'b1; step(); rst = 1'b0; step();
    pulse = 4'b0101; exp_q.push_back(0); exp_q.push_back(2);
    step(); pulse = 4'd0;
    wait_idle();

    // Re-press arriving in the grant cycle stays pending, no drop
    pulse = 4'b0100; exp_q.push_back(2); exp_q.push_back(2);
    step();
    step(); pulse = 4'd0;
    chk("regrant_pending", {28'd0, pending}, 32'h4);
    chk("regrant_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
    chk("regrant_no_drop", {31'd0, dropped}, 32'd0);
    wait_idle();

    // Backpressure: ID 3 held stable for 10 cycles, accepted when ready returns
    cmd_if.cmd_ready = 1'b0;
    pulse = 4'b1000; exp_q.push_back(3);
    step(); pulse = 4'd0;
    step();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
      chk("bp_id", {30'd0, cmd_if.cmd_id}, 32'd3);
      step();
    end
    cmd_if.cmd_ready = 1'b1;
    step();
    chk("bp_accepted", {31'd0, cmd_if.cmd_valid}, 32'd0);
    wait_idle();

    // Drop: ID 1 pressed twice while an ID 0 offer is stalled
    cmd_if.cmd_ready = 1'b0;
    pulse = 4'b0001; exp_q.push_back(0);
    step(); pulse = 4'd0;
    step();
    pulse = 4'b0010;
    step(); pulse = 4'd0;
    chk("drop_first_pending", {28'd0, pending}, 32'h2);
    chk("drop_first_clean", {31'd0, dropped}, 32'd0);
    pulse = 4'b0010;
    step(); pulse = 4'd0;
    chk("drop_set", {31'd0, dropped}, 32'd1);
    chk("drop_pending", {28'd0, pending}, 32'h2);
    exp_q.push_back(1);
    cmd_if.cmd_ready = 1'b1;
    wait_idle();
    chk("drop_sticky", {31'd0, dropped}, 32'd1);

    // Enable low mid-offer: offer completes, pending clears, nothing new
    cmd_if.cmd_ready = 1'b0;
    pulse = 4'b0001; exp_q.push_back(0);
    step(); pulse = 4'd0;
    step();
    pulse = 4'b0100;
    step(); pulse = 4'd0;
    chk("en_pending_before", {28'd0, pending}, 32'h4);
    enable = 1'b0;
    step();
    chk("en_pending_clr", {28'd0, pending}, 32'd0);
    chk("en_offer_held", {31'd0, cmd_if.cmd_valid}, 32'd1);
    chk("en_offer_id", {30'd0, cmd_if.cmd_id}, 32'd0);
    cmd_if.cmd_ready = 1'b1;
    step();
    chk("en_offer_done", {31'd0, cmd_if.cmd_valid}, 32'd0);
    pulse = 4'b0010;
    step(); pulse = 4'd0;
    step();
    chk("en_no_latch", {28'd0, pending}, 32'd0);
    chk("en_no_grant", {31'd0, cmd_if.cmd_valid}, 32'd0);
    enable = 1'b1;
    step();

    // Reset mid-offer drops valid without a clock edge; the command is lost
    cmd_if.cmd_ready = 1'b0;
    pulse = 4'b0010;
    step(); pulse = 4'd0;
    step();
    chk("rst_offer_up", {31'd0, cmd_if.cmd_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
    chk("rst_async_dropped", {31'd0, dropped}, 32'd0);
    step(); rst = 1'b0; cmd_if.cmd_ready = 1'b1;
    step(); step();
    chk("rst_after_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);

`ifdef PADDLE_AUTO_REPEAT_EN
    // Held button repeats every 8 cycles: offers visible 9 and 17 edges after held rises
    held = 4'b0100; exp_q.push_back(2); exp_q.push_back(2);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9 || k == 17) begin
        chk("rpt_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        chk("rpt_id", {30'd0, cmd_if.cmd_id}, 32'd2);
      end
    end
    held = 4'd0;
    wait_idle();
`endif

    step(); step();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
